// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execution unit. Decodes ALUOp/funct and registers the
// result of single-cycle ops one cycle after acceptance. MUL runs as an iterative
// shift-add that retires MUL_BITS multiplier bits per cycle. An optional restoring
// unsigned divider is enabled by defining ALU_EXEC_DIV_EN; without that macro,
// funct 011010 decodes as illegal.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a request; single-cycle ops complete from here
// S_BUSY | multi-cycle op iterating; counter reaching 0 marks the last step
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             illegal_o,
    output logic             stall_o
);

    localparam int               MUL_ITERS = WIDTH / MUL_BITS;
    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_ITERS - 1);
`ifdef ALU_EXEC_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;
    typedef enum logic [1:0] {K_SINGLE, K_MUL, K_DIV} kind_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             finish;

    kind_t            dec_kind;
    logic [WIDTH-1:0] dec_result;
    logic             dec_ovf;
    logic             dec_illegal;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    // op_a: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // op_b: multiplier (MUL) or divisor (DIV)
    // acc : product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] op_a_nxt;
    logic [WIDTH-1:0] op_b_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] digit_ext;

`ifdef ALU_EXEC_DIV_EN
    logic             is_div;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;
`endif

    assign sum     = data1_i + data2_i;
    assign diff    = data1_i - data2_i;
    // Signed overflow: operands of matching (add) or differing (sub) sign yield a
    // result whose sign differs from operand A.
    assign add_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (sum[WIDTH-1] != data1_i[WIDTH-1]);
    assign sub_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (diff[WIDTH-1] != data1_i[WIDTH-1]);

    assign ready_o = (state == S_IDLE);
    assign stall_o = ~ready_o;

    // Decode ALUOp/funct into an op kind and the single-cycle result/flags.
    always_comb begin
        dec_kind    = K_SINGLE;
        dec_result  = '0;
        dec_ovf     = 1'b0;
        dec_illegal = 1'b0;
        case (ALUOp_i)
            2'b00: begin
                dec_result = sum;
                dec_ovf    = add_ovf;
            end
            2'b01: begin
                dec_result = diff;
                dec_ovf    = sub_ovf;
            end
            2'b10: begin
                case (funct_i)
                    6'b100100: dec_result = data1_i & data2_i;
                    6'b100101: dec_result = data1_i | data2_i;
                    6'b100000: begin
                        dec_result = sum;
                        dec_ovf    = add_ovf;
                    end
                    6'b100010: begin
                        dec_result = diff;
                        dec_ovf    = sub_ovf;
                    end
                    6'b101010: dec_result = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
                    6'b011000: dec_kind = K_MUL;
                    6'b000000: dec_result = '0;
`ifdef ALU_EXEC_DIV_EN
                    6'b011010: dec_kind = K_DIV;
`endif
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; flush beats completion, and a flushed request is never accepted.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!flush_i && valid_i) begin
                    accept = 1'b1;
                    if (dec_kind != K_SINGLE) begin
                        state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration step: shift-add for MUL, one restoring step for DIV.
    always_comb begin
        digit_ext   = {{(WIDTH-MUL_BITS){1'b0}}, op_b[MUL_BITS-1:0]};
        acc_nxt     = acc + (op_a * digit_ext);
        op_a_nxt    = op_a << MUL_BITS;
        op_b_nxt    = op_b >> MUL_BITS;
        iter_result = acc_nxt;
`ifdef ALU_EXEC_DIV_EN
        rem_shift   = {acc, op_a[WIDTH-1]};
        rem_ge      = (rem_shift >= {1'b0, op_b});
        rem_diff    = WIDTH'(rem_shift - {1'b0, op_b});
        if (is_div) begin
            // A zero divisor always compares lower, giving an all-ones quotient.
            acc_nxt     = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
            op_a_nxt    = {op_a[WIDTH-2:0], rem_ge};
            op_b_nxt    = op_b;
            iter_result = op_a_nxt;
        end
`endif
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o  <= '0;
            valid_o   <= 1'b0;
            ovf_o     <= 1'b0;
            illegal_o <= 1'b0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
`ifdef ALU_EXEC_DIV_EN
            is_div    <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                cnt <= '0;
            end else if (state == S_BUSY) begin
                op_a <= op_a_nxt;
                op_b <= op_b_nxt;
                acc  <= acc_nxt;
                if (finish) begin
                    cnt       <= '0;
                    result_o  <= iter_result;
                    valid_o   <= 1'b1;
                    ovf_o     <= 1'b0;
                    illegal_o <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (accept) begin
                if (dec_kind == K_SINGLE) begin
                    result_o  <= dec_result;
                    valid_o   <= 1'b1;
                    ovf_o     <= dec_ovf;
                    illegal_o <= dec_illegal;
                end else begin
                    op_a <= data1_i;
                    op_b <= data2_i;
                    acc  <= '0;
                    cnt  <= MUL_LAST;
`ifdef ALU_EXEC_DIV_EN
                    is_div <= (dec_kind == K_DIV);
                    if (dec_kind == K_DIV) begin
                        cnt <= DIV_LAST;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_alu_exec_unit;

    localparam int W       = 32;
    localparam int MB      = 1;
    localparam int MUL_LAT = W / MB;
    localparam int DIV_LAT = W;

    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_NOP = 6'b000000;
    localparam logic [5:0] F_DIV = 6'b011010;
    localparam logic [5:0] F_BAD = 6'b000111;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         valid = 1'b0;
    logic [1:0]   alu_op = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic [W-1:0] data1 = '0;
    logic [W-1:0] data2 = '0;
    logic         ready_o, valid_o, ovf_o, illegal_o, stall_o;
    logic [W-1:0] result_o;

    logic         valid4 = 1'b0;
    logic [1:0]   alu_op4 = 2'b00;
    logic [5:0]   funct4 = 6'b0;
    logic [W-1:0] a4 = '0;
    logic [W-1:0] b4 = '0;
    logic         ready4, valid4_o, ovf4, ill4, stall4;
    logic [W-1:0] result4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .MUL_BITS(MB)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready_o),
        .ALUOp_i(alu_op), .funct_i(funct), .data1_i(data1), .data2_i(data2),
        .result_o(result_o), .valid_o(valid_o), .ovf_o(ovf_o), .illegal_o(illegal_o),
        .stall_o(stall_o)
    );

    alu_exec_unit #(.WIDTH(W), .MUL_BITS(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .valid_i(valid4), .ready_o(ready4),
        .ALUOp_i(alu_op4), .funct_i(funct4), .data1_i(a4), .data2_i(b4),
        .result_o(result4), .valid_o(valid4_o), .ovf_o(ovf4), .illegal_o(ill4),
        .stall_o(stall4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: what an op must produce, and how many cycles it stays busy (0 = single cycle).
    function automatic void ref_op(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic ov,
                                   output logic il, output int lat);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; ov = 1'b0; il = 1'b0; lat = 0;
        if (op == 2'b00 || (op == 2'b10 && fn == F_ADD)) begin
            s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b01 || (op == 2'b10 && fn == F_SUB)) begin
            s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b11) begin
            il = 1'b1;
        end else if (fn == F_AND) r = a & b;
        else if (fn == F_OR)  r = a | b;
        else if (fn == F_SLT) r = (sa < sb) ? 1 : 0;
        else if (fn == F_NOP) r = '0;
        else if (fn == F_MUL) begin r = a * b; lat = MUL_LAT; end
`ifdef ALU_EXEC_DIV_EN
        else if (fn == F_DIV) begin r = (b == 0) ? '1 : a / b; lat = DIV_LAT; end
`endif
        else il = 1'b1;
    endfunction

    // Behavioural model: busy countdown plus the last presented result.
    logic         m_live = 1'b0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_pend = '0;
    logic         m_ovf = 1'b0;
    logic         m_ill = 1'b0;
    int           m_busy = 0;

    always @(posedge clk) begin
        logic [W-1:0] r;
        logic ov, il;
        int lat;
        m_valid = 1'b0;
        if (rst) begin
            m_live = 1'b1; m_busy = 0; m_result = '0; m_ovf = 1'b0; m_ill = 1'b0;
        end else if (flush) begin
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1'b1; m_result = m_pend; m_ovf = 1'b0; m_ill = 1'b0;
            end
        end else if (valid) begin
            ref_op(alu_op, funct, data1, data2, r, ov, il, lat);
            if (lat == 0) begin
                m_valid = 1'b1; m_result = r; m_ovf = ov; m_ill = il;
            end else begin
                m_busy = lat; m_pend = r;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_valid", valid_o, m_valid);
            check("cyc_ready", ready_o, m_busy == 0);
            check("cyc_stall", stall_o, m_busy != 0);
            check("cyc_result", result_o, m_result);
            if (m_valid) begin
                check("cyc_ovf", ovf_o, m_ovf);
                check("cyc_illegal", illegal_o, m_ill);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_op = op; funct = fn; data1 = a; data2 = b; valid = 1'b1;
    endtask

    // Cycles from the accepting edge to the valid_o cycle, and stall cycles seen before it.
    task automatic wait_valid(input bit use4, output int k, output int stalls);
        bit found;
        found = 1'b0; k = -1; stalls = 0;
        for (int c = 1; c <= 200 && !found; c++) begin
            @(negedge clk);
            if (use4 ? valid4_o : valid_o) begin
                k = c; found = 1'b1;
            end else begin
                if (use4 ? stall4 : stall_o) stalls++;
                tick();
            end
        end
    endtask

    task automatic count_valids(input int n, output int pulses);
        pulses = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (valid_o) pulses++;
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s, p;
        logic [W-1:0] pool [5];
        pool[0] = 32'h7FFF_FFFF; pool[1] = 32'h8000_0000; pool[2] = 32'h0;
        pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h1;

        // T1 reset held two cycles
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        @(negedge clk);
        check("rst_result", result_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_stall", stall_o, 0);
        check("rst_ready4", ready4, 1);

        // T2 back-to-back single-cycle ops
        drive(2'b00, F_NOP, 7, 5); tick();
        drive(2'b01, F_NOP, 5, 7);
        @(negedge clk); check("add_res", result_o, 12); check("add_valid", valid_o, 1); tick();
        drive(2'b10, F_SLT, 32'hFFFF_FFFF, 1);
        @(negedge clk); check("sub_res", result_o, 32'hFFFF_FFFE); check("sub_valid", valid_o, 1); tick();
        drive(2'b10, F_AND, 32'hF0F0, 32'hFF00);
        @(negedge clk); check("slt_res", result_o, 1); check("slt_valid", valid_o, 1); tick();
        drive(2'b00, F_NOP, 32'h7FFF_FFFF, 1);
        @(negedge clk); check("and_res", result_o, 32'hF000); check("and_valid", valid_o, 1); tick();
        valid = 1'b0;
        @(negedge clk); check("ovf_res", result_o, 32'h8000_0000); check("ovf_flag", ovf_o, 1);
        check("ovf_valid", valid_o, 1); tick();
        @(negedge clk); check("seq_end_valid", valid_o, 0);

        // T3 multiply latency and result
        drive(2'b10, F_MUL, 1234, 5678); tick(); valid = 1'b0;
        wait_valid(1'b0, k, s);
        check("mul1_latency", k, 33); check("mul1_stalls", s, 32);
        check("mul1_result", result_o, 7006652); tick();
        drive(2'b10, F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick(); valid = 1'b0;
        wait_valid(1'b0, k, s);
        check("mulff_latency", k, 33); check("mulff_result", result_o, 1); tick();
        alu_op4 = 2'b10; funct4 = F_MUL; a4 = 1234; b4 = 5678; valid4 = 1'b1; tick(); valid4 = 1'b0;
        wait_valid(1'b1, k, s);
        check("mul4_latency", k, 9); check("mul4_stalls", s, 8);
        check("mul4_result", result4, 7006652); check("mul4_ovf", ovf4, 0); tick();

        // T4 requests during BUSY are ignored
        drive(2'b10, F_MUL, 3, 4); tick();
        drive(2'b00, F_NOP, 100, 200); tick(); tick(); tick(); tick();
        valid = 1'b0;
        count_valids(40, p);
        check("busy_pulses", p, 1); check("busy_result", result_o, 12);

        // flush at cycle 10 of a multiply
        drive(2'b10, F_MUL, 1234, 5678); tick(); valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        @(negedge clk);
        check("flush_ready", ready_o, 1); check("flush_valid", valid_o, 0);
        check("flush_result", result_o, 12); tick();
        count_valids(40, p);
        check("flush_pulses", p, 0);

        // same-edge request and flush: dropped
        drive(2'b00, F_NOP, 1, 1); flush = 1'b1; tick(); flush = 1'b0; valid = 1'b0;
        @(negedge clk); check("flushreq_valid", valid_o, 0); check("flushreq_result", result_o, 12);

        // reset mid-multiply
        drive(2'b10, F_MUL, 9, 9); tick(); valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("rstmul_ready", ready_o, 1); check("rstmul_valid", valid_o, 0);
        check("rstmul_result", result_o, 0); tick();
        count_valids(40, p);
        check("rstmul_pulses", p, 0);

        // T5 illegal and nop
        drive(2'b00, F_NOP, 3, 4); tick();
        drive(2'b11, F_NOP, 5, 6);
        @(negedge clk); check("pre_ill_res", result_o, 7); tick();
        drive(2'b10, F_BAD, 5, 6);
        @(negedge clk); check("ill_op_valid", valid_o, 1); check("ill_op_flag", illegal_o, 1);
        check("ill_op_res", result_o, 0); tick();
        drive(2'b00, F_NOP, 1, 2);
        @(negedge clk); check("ill_fn_flag", illegal_o, 1); check("ill_fn_res", result_o, 0); tick();
        drive(2'b10, F_NOP, 9, 9);
        @(negedge clk); check("pre_nop_res", result_o, 3); tick();
        valid = 1'b0;
        @(negedge clk); check("nop_valid", valid_o, 1); check("nop_flag", illegal_o, 0);
        check("nop_res", result_o, 0); tick();

        // T6 divide
`ifdef ALU_EXEC_DIV_EN
        drive(2'b10, F_DIV, 100, 7); tick(); valid = 1'b0;
        wait_valid(1'b0, k, s);
        check("div_latency", k, 33); check("div_result", result_o, 14); tick();
        drive(2'b10, F_DIV, 12345, 0); tick(); valid = 1'b0;
        wait_valid(1'b0, k, s);
        check("div0_result", result_o, 32'hFFFF_FFFF); check("div0_flag", illegal_o, 0); tick();
`else
        drive(2'b10, F_DIV, 100, 7); tick(); valid = 1'b0;
        @(negedge clk); check("nodiv_valid", valid_o, 1); check("nodiv_flag", illegal_o, 1);
        check("nodiv_res", result_o, 0); tick();
`endif

        // randomized phase, checked by the model
        for (int i = 0; i < 3000; i++) begin
            int sel;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 59) == 0);
            valid = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            alu_op = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            case ($urandom_range(0, 9))
                0: funct = F_AND;  1: funct = F_OR;  2: funct = F_ADD; 3: funct = F_SUB;
                4: funct = F_SLT;  5: funct = F_MUL; 6: funct = F_NOP; 7: funct = F_DIV;
                8: funct = F_BAD;  default: funct = 6'($urandom);
            endcase
            data1 = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            data2 = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            tick();
        end
        rst = 1'b0; flush = 1'b0; valid = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
